core_pipe_ctrl: RTL and testbench

//  Parametrised in-order N-stage pipeline controller for the next-generation core top.

---
 rtl/core_pipe_pkg.sv | 31 +++
 rtl/core_pipe_slot.sv | 40 ++++
 rtl/core_pipe_ctrl.sv | 168 ++++++++++++++++
 tb/tb_core_pipe_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pipe_pkg.sv
// core_pipe_pkg: shared types and helpers for the in-order pipeline controller.
//   TAG_REGW   : register-id width carried in each slot tag. The controller's
//                REG_ADDRW parameter must not exceed this width.
//   stg_idx_w  : width of a slot index for a given stage count (minimum 1).
//   STG_IDXW   : slot index width for the default 5-stage configuration.
//   slot_t     : per-slot control tag {valid, rdid, rdwen, lden}.
//   fwd_t      : forward-source descriptor {hit, idx} for the default configuration.
package core_pipe_pkg;

    localparam int TAG_REGW   = 5;
    localparam int DEF_STAGES = 5;

    function automatic int stg_idx_w(input int stages);
        return (stages > 1) ? $clog2(stages) : 1;
    endfunction

    localparam int STG_IDXW = stg_idx_w(DEF_STAGES);

    typedef struct packed {
        logic                valid;
        logic [TAG_REGW-1:0] rdid;
        logic                rdwen;
        logic                lden;
    } slot_t;

    typedef struct packed {
        logic                hit;
        logic [STG_IDXW-1:0] idx;
    } fwd_t;

endpackage

// File: rtl/core_pipe_slot.sv
// core_pipe_slot: one elastic pipeline slot (control tag plus payload register).
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset (clears tag and payload)
//   i_load       : capture i_tag / i_pld (the upstream content moves in)
//   i_clear      : drop valid (content moved on with nothing arriving)
//   i_kill       : drop valid because of a flush; beats load and clear
//   i_tag, i_pld : incoming content
//   o_tag, o_pld : held content
// The payload is only written on a load, so bubbles keep the stale payload.
module core_pipe_slot
    import core_pipe_pkg::*;
#(
    parameter int PLD_W = 96
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_clear,
    input  logic             i_kill,
    input  slot_t            i_tag,
    input  logic [PLD_W-1:0] i_pld,
    output slot_t            o_tag,
    output logic [PLD_W-1:0] o_pld
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_tag <= '0;
            o_pld <= '0;
        end else if (i_kill) begin
            o_tag.valid <= 1'b0;
        end else if (i_load) begin
            o_tag <= i_tag;
            o_pld <= i_pld;
        end else if (i_clear) begin
            o_tag.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/core_pipe_ctrl.sv
// core_pipe_ctrl: parametrised in-order STAGES-slot pipeline controller.
// Slot 0 is the youngest, slot STAGES-1 the oldest (retirement slot).
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_in_valid/o_in_ready   : entry handshake into slot 0
//   i_in_pld, i_in_rdid,
//   i_in_rdwen, i_in_lden   : entry payload and destination tag
//   i_rs1id, i_rs2id        : entry source registers (hazard / forward query)
//   i_stg_busy[k]           : slot k must hold its content this cycle
//   i_flush, i_flush_stg    : kill every slot younger than i_flush_stg
//   o_hz_stall              : load-use hazard blocks the entry
//   o_rs1_fwd, o_rs2_fwd    : {hit, youngest matching slot index}
//   o_stg_valid, o_stg_pld  : slot valid bits and flattened payloads
//   o_out_valid/i_out_ready : retirement handshake from slot STAGES-1
// Optional build macro PIPE_PERF_EN adds o_perf_retire / o_perf_stall
// (64-bit wrapping counters of retirements and stalled entry cycles).
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and content offered with valid
// high stays put until it transfers (or is killed by flush/reset).
module core_pipe_ctrl
    import core_pipe_pkg::*;
#(
    parameter int STAGES     = 5,
    parameter int PLD_W      = 96,
    parameter int REG_ADDRW  = TAG_REGW,
    parameter int LD_RDY_STG = 3
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [PLD_W-1:0]            i_in_pld,
    input  logic [REG_ADDRW-1:0]        i_in_rdid,
    input  logic                        i_in_rdwen,
    input  logic                        i_in_lden,
    input  logic [REG_ADDRW-1:0]        i_rs1id,
    input  logic [REG_ADDRW-1:0]        i_rs2id,
    input  logic [STAGES-1:0]           i_stg_busy,
    input  logic                        i_flush,
    input  logic [$clog2(STAGES)-1:0]   i_flush_stg,
    output logic                        o_hz_stall,
    output logic [$clog2(STAGES):0]     o_rs1_fwd,
    output logic [$clog2(STAGES):0]     o_rs2_fwd,
    output logic [STAGES-1:0]           o_stg_valid,
    output logic [STAGES*PLD_W-1:0]     o_stg_pld,
    output logic                        o_out_valid,
    input  logic                        i_out_ready
`ifdef PIPE_PERF_EN
    ,
    output logic [63:0]                 o_perf_retire,
    output logic [63:0]                 o_perf_stall
`endif
);

    localparam int IW = stg_idx_w(STAGES);

    slot_t            tag     [STAGES];
    slot_t            src_tag [STAGES];
    logic [PLD_W-1:0] pld     [STAGES];
    logic [PLD_W-1:0] src_pld [STAGES];
    logic [STAGES-1:0] valid, adv, load, kill;
    logic              rs1_hit, rs2_hit, rs1_ld, rs2_ld;
    logic [IW-1:0]     rs1_idx, rs2_idx;

    // Advance chain: a slot moves on when it is valid, not busy and the slot
    // ahead is empty or itself moving on this cycle.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = valid[STAGES-1] & ~i_stg_busy[STAGES-1] & i_out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = valid[k] & ~i_stg_busy[k] & (~valid[k+1] | adv[k+1]);
        end
    end

    // Flush kills slots strictly younger than the resolving slot, regardless of busy.
    always_comb begin
        kill = '0;
        for (int k = 0; k < STAGES; k++) begin
            kill[k] = i_flush & (IW'(k) < i_flush_stg);
        end
    end

    // Hazard scan runs oldest to youngest so the youngest match is written last.
    always_comb begin
        rs1_hit = 1'b0;
        rs1_idx = '0;
        rs1_ld  = 1'b0;
        rs2_hit = 1'b0;
        rs2_idx = '0;
        rs2_ld  = 1'b0;
        for (int j = STAGES - 1; j >= 0; j--) begin
            if (tag[j].valid && tag[j].rdwen && (i_rs1id != '0) &&
                (tag[j].rdid == TAG_REGW'(i_rs1id))) begin
                rs1_hit = 1'b1;
                rs1_idx = IW'(j);
                rs1_ld  = tag[j].lden && (j < LD_RDY_STG);
            end
            if (tag[j].valid && tag[j].rdwen && (i_rs2id != '0) &&
                (tag[j].rdid == TAG_REGW'(i_rs2id))) begin
                rs2_hit = 1'b1;
                rs2_idx = IW'(j);
                rs2_ld  = tag[j].lden && (j < LD_RDY_STG);
            end
        end
    end

    assign o_hz_stall = i_in_valid & (rs1_ld | rs2_ld);
    assign o_rs1_fwd  = {rs1_hit, rs1_idx};
    assign o_rs2_fwd  = {rs2_hit, rs2_idx};
    assign o_in_ready = ~i_rst & (~valid[0] | adv[0]) & ~o_hz_stall & ~i_flush;

    // Slot k loads from k-1; a killed slot never hands its content onward.
    always_comb begin
        src_tag[0]       = '0;
        src_tag[0].valid = 1'b1;
        src_tag[0].rdid  = TAG_REGW'(i_in_rdid);
        src_tag[0].rdwen = i_in_rdwen;
        src_tag[0].lden  = i_in_lden;
        src_pld[0]       = i_in_pld;
        load             = '0;
        load[0]          = i_in_valid & o_in_ready;
        for (int k = 1; k < STAGES; k++) begin
            src_tag[k] = tag[k-1];
            src_pld[k] = pld[k-1];
            load[k]    = adv[k-1] & ~kill[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_slot
        core_pipe_slot #(
            .PLD_W (PLD_W)
        ) u_slot (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_load  (load[k]),
            .i_clear (adv[k]),
            .i_kill  (kill[k]),
            .i_tag   (src_tag[k]),
            .i_pld   (src_pld[k]),
            .o_tag   (tag[k]),
            .o_pld   (pld[k])
        );
        assign valid[k]                     = tag[k].valid;
        assign o_stg_pld[k*PLD_W +: PLD_W] = pld[k];
    end

    assign o_stg_valid = valid;
    assign o_out_valid = valid[STAGES-1];

`ifdef PIPE_PERF_EN
    // A retirement is the oldest slot actually leaving (busy holds it back).
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_perf_retire <= '0;
            o_perf_stall  <= '0;
        end else begin
            if (adv[STAGES-1]) begin
                o_perf_retire <= o_perf_retire + 64'd1;
            end
            if (i_in_valid && !o_in_ready) begin
                o_perf_stall <= o_perf_stall + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// tb_core_pipe_ctrl: directed bench for core_pipe_ctrl (STAGES=5, LD_RDY_STG=3).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// An expected-payload queue follows accepted entries and is checked at retirement.
// Build with PIPE_PERF_EN defined to also connect and check the perf counters.
module tb_core_pipe_ctrl;

    localparam int S  = 5;
    localparam int PW = 96;
    localparam int RW = 5;
    localparam int IW = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid, in_ready;
    logic [PW-1:0]       in_pld;
    logic [RW-1:0]       in_rdid, rs1id, rs2id;
    logic                in_rdwen, in_lden;
    logic [S-1:0]        stg_busy;
    logic                flush;
    logic [IW-1:0]       flush_stg;
    logic                hz_stall;
    logic [IW:0]         rs1_fwd, rs2_fwd;
    logic [S-1:0]        stg_valid;
    logic [S*PW-1:0]     stg_pld;
    logic                out_valid, out_ready;
    logic [PW-1:0]       out_pld;
`ifdef PIPE_PERF_EN
    logic [63:0]         perf_retire, perf_stall;
`endif

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] exp_v;
    int checks = 0, failures = 0, cyc = 0;
    int ret_cnt = 0, first_ret = -1, last_ret = -1, t0 = 0;

    assign out_pld = stg_pld[(S-1)*PW +: PW];

    core_pipe_ctrl #(
        .STAGES(S), .PLD_W(PW), .REG_ADDRW(RW), .LD_RDY_STG(3)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_in_pld    (in_pld),
        .i_in_rdid   (in_rdid),
        .i_in_rdwen  (in_rdwen),
        .i_in_lden   (in_lden),
        .i_rs1id     (rs1id),
        .i_rs2id     (rs2id),
        .i_stg_busy  (stg_busy),
        .i_flush     (flush),
        .i_flush_stg (flush_stg),
        .o_hz_stall  (hz_stall),
        .o_rs1_fwd   (rs1_fwd),
        .o_rs2_fwd   (rs2_fwd),
        .o_stg_valid (stg_valid),
        .o_stg_pld   (stg_pld),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready)
`ifdef PIPE_PERF_EN
        ,
        .o_perf_retire (perf_retire),
        .o_perf_stall  (perf_stall)
`endif
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [PW-1:0] mk_pld(input int id);
        return {32'hA5A5_0000 | 32'(id), 32'(id * 3), ~32'(id)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        in_valid  = 1'b0;
        in_pld    = '0;
        in_rdid   = '0;
        in_rdwen  = 1'b0;
        in_lden   = 1'b0;
        rs1id     = '0;
        rs2id     = '0;
        stg_busy  = '0;
        flush     = 1'b0;
        flush_stg = '0;
        out_ready = 1'b1;
    endtask

    task automatic offer(input int id, input logic [RW-1:0] rd, input logic rdwen,
                         input logic lden, input logic [RW-1:0] rs1, input logic [RW-1:0] rs2);
        in_valid = 1'b1;
        in_pld   = mk_pld(id);
        in_rdid  = rd;
        in_rdwen = rdwen;
        in_lden  = lden;
        rs1id    = rs1;
        rs2id    = rs2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard bookkeeping for the current cycle, then move to the next falling edge.
    task automatic step();
        if (!rst && in_valid && in_ready) exp_q.push_back(in_pld);
        if (!rst && out_valid && out_ready && !stg_busy[S-1]) begin
            if (first_ret < 0) first_ret = cyc;
            last_ret = cyc;
            ret_cnt++;
            check("retire_q_nonempty", 128'(exp_q.size() != 0), 128'(1'b1));
            if (exp_q.size() != 0) begin
                exp_v = exp_q.pop_front();
                check("retire_pld", 128'(out_pld), 128'(exp_v));
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        step();
    endtask

    task automatic drain(input string tag);
        drive_idle();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) cycle();
        check(tag, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        // reset
        rst = 1'b1;
        drive_idle();
        @(negedge clk);
        @(negedge clk);
        settle();
        check("rst_in_ready", 128'(in_ready), 128'(1'b0));
        check("rst_valid", 128'(stg_valid), 128'(5'b00000));
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_pld_zero", 128'(|stg_pld), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;

        // back-to-back 10 entries
        ret_cnt   = 0;
        first_ret = -1;
        t0        = cyc;
        for (int i = 1; i <= 10; i++) begin
            offer(i, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
            settle();
            check("b2b_in_ready", 128'(in_ready), 128'(1'b1));
            step();
        end
        drain("b2b_drain");
        check("b2b_count", 128'(ret_cnt), 128'(10));
        check("b2b_latency", 128'(first_ret - t0), 128'(5));
        check("b2b_rate", 128'(last_ret - first_ret), 128'(9));

        // busy on slot 2 with a full pipe
        out_ready = 1'b0;
        for (int i = 11; i <= 15; i++) begin
            offer(i, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
            cycle();
        end
        offer(16, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        out_ready = 1'b1;
        stg_busy  = 5'b00100;
        settle();
        check("busy_full", 128'(stg_valid), 128'(5'b11111));
        check("busy_in_ready", 128'(in_ready), 128'(1'b0));
        step();
        settle();
        check("busy_valid1", 128'(stg_valid), 128'(5'b10111));
        check("busy_in_ready", 128'(in_ready), 128'(1'b0));
        step();
        settle();
        check("busy_valid2", 128'(stg_valid), 128'(5'b00111));
        check("busy_in_ready", 128'(in_ready), 128'(1'b0));
        step();
        stg_busy = '0;
        settle();
        check("busy_release_ready", 128'(in_ready), 128'(1'b1));
        step();
        drain("busy_drain");

        // load-use hazard
        offer(20, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0);
        cycle();
        offer(21, 5'd0, 1'b0, 1'b0, 5'd5, 5'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("ld_stall", 128'(hz_stall), 128'(1'b1));
            check("ld_in_ready", 128'(in_ready), 128'(1'b0));
            check("ld_fwd_idx", 128'(rs1_fwd), 128'({1'b1, 3'(i)}));
            step();
        end
        settle();
        check("ld_stall_end", 128'(hz_stall), 128'(1'b0));
        check("ld_accept", 128'(in_ready), 128'(1'b1));
        check("ld_rs1_fwd", 128'(rs1_fwd), 128'(4'b1011));
        step();

        // ALU forward from slots 1 and 3, x0 never hits
        offer(30, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
        cycle();
        offer(31, 5'd0, 1'b1, 1'b0, 5'd0, 5'd0);
        cycle();
        offer(32, 5'd7, 1'b1, 1'b0, 5'd0, 5'd0);
        cycle();
        offer(33, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
        settle();
        check("alu_fwd_slot0", 128'(rs2_fwd), 128'(4'b1000));
        check("alu_no_stall0", 128'(hz_stall), 128'(1'b0));
        step();
        offer(34, 5'd0, 1'b0, 1'b0, 5'd0, 5'd7);
        settle();
        check("alu_rs2_fwd", 128'(rs2_fwd), 128'(4'b1001));
        check("alu_no_stall", 128'(hz_stall), 128'(1'b0));
        check("alu_in_ready", 128'(in_ready), 128'(1'b1));
        check("x0_no_hit", 128'(rs1_fwd[IW]), 128'(1'b0));
        step();
        drain("alu_drain");

        // partial flush from slot 2, busy on a killed slot
        out_ready = 1'b0;
        for (int i = 40; i <= 44; i++) begin
            offer(i, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
            cycle();
        end
        offer(45, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        out_ready = 1'b1;
        flush     = 1'b1;
        flush_stg = 3'd2;
        stg_busy  = 5'b00010;
        settle();
        check("flush_in_ready", 128'(in_ready), 128'(1'b0));
        step();
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        drive_idle();
        settle();
        check("flush_valid", 128'(stg_valid), 128'(5'b11000));
        check("flush_slot3", 128'(stg_pld[3*PW +: PW]), 128'(mk_pld(42)));
        check("flush_slot4", 128'(stg_pld[4*PW +: PW]), 128'(mk_pld(41)));
        step();
        drain("flush_drain");

        // flush from slot 0 kills nothing but still refuses entry
        out_ready = 1'b0;
        for (int i = 50; i <= 53; i++) begin
            offer(i, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
            cycle();
        end
        offer(54, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        flush     = 1'b1;
        flush_stg = 3'd0;
        settle();
        check("flush0_in_ready", 128'(in_ready), 128'(1'b0));
        step();
        flush = 1'b0;
        settle();
        check("flush0_valid", 128'(stg_valid), 128'(5'b11110));

        // reset mid-stream with busy and flush active
        rst       = 1'b1;
        stg_busy  = '1;
        flush     = 1'b1;
        flush_stg = 3'd3;
        out_ready = 1'b1;
        step();
        exp_q.delete();
        settle();
        check("midrst_valid", 128'(stg_valid), 128'(5'b00000));
        check("midrst_out_valid", 128'(out_valid), 128'(1'b0));
        check("midrst_in_ready", 128'(in_ready), 128'(1'b0));
`ifdef PIPE_PERF_EN
        check("midrst_perf_retire", 128'(perf_retire), 128'(0));
        check("midrst_perf_stall", 128'(perf_stall), 128'(0));
`endif
        step();
        rst = 1'b0;
        drive_idle();
        offer(60, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
        settle();
        check("post_rst_ready", 128'(in_ready), 128'(1'b1));
        step();
        drain("post_rst_drain");

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
